// File: rtl/alu_pkg.sv
// Shared definitions for the sequential divider: default sizes and FSM state encoding.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/alu_div_seq_if.sv
// Start/done handshake and operand/result bus between the execute stage and the divider.
interface alu_div_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem_c,
    output logic             o_qbit_c
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};

    // A set top bit in the shifted value always exceeds the divisor; otherwise bit WIDTH is the borrow.
    assign o_qbit_c = w_shift[WIDTH] | ~w_diff[WIDTH];
    assign o_rem_c  = o_qbit_c ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider, unsigned and two's-complement signed, one quotient bit per cycle.
module alu_div_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_div_seq_if.slave  bus
);
    state_t           r_state;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;

    logic [WIDTH-1:0] w_rem;
    logic             w_qbit;
    logic             w_dvd_neg;
    logic             w_dvs_neg;

    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_dvd[WIDTH-1]),
        .i_dvs    (r_dvs),
        .o_rem_c  (w_rem),
        .o_qbit_c (w_qbit)
    );

    // r_dvd shifts out dividend bits from the top and collects quotient bits at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quo   <= '0;
            r_rmd   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quo   <= '1;
                            r_rmd   <= bus.dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_dvd   <= bus.dividend;
                            r_dvs   <= bus.divisor;
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
                            r_busy  <= 1'b1;
                            r_state <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    // Divisor sign is recovered from the two latched sign flags.
                    if (r_neg_r)           r_dvd <= -r_dvd;
                    if (r_neg_q ^ r_neg_r) r_dvs <= -r_dvs;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_rem <= w_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_quo   <= r_neg_q ? -r_dvd : r_dvd;
                    r_rmd   <= r_neg_r ? -r_rem : r_rem;
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rmd;
    assign bus.div_by_zero = r_dbz;
endmodule
